mux_arb_reg: RTL and testbench
==============================

MUX_ARB_REG -- requirements
Module: mux_arb_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width per channel.
REQ-002 SHALL have parameter NUM_IN, default 4, number of input channels (legal range 2..16).
REQ-003 SHALL derive localparam SEL_W = max(1, clog2(NUM_IN)).
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-008 sel  input  SEL_W  channel index used in fixed mode.
REQ-009 flush  input  1  discard held output, reset arbitration pointer.
REQ-010 in_data  input  NUM_IN*WIDTH  flattened channels; channel i at bits [i*WIDTH +: WIDTH].
REQ-011 in_valid  input  NUM_IN  per-channel valid.
REQ-012 in_ready  output  NUM_IN  per-channel ready, at most one bit set.
REQ-013 out_data  output  WIDTH  registered selected data.
REQ-014 out_valid  output  1  out_data holds an unconsumed word.
REQ-015 out_ready  input  1  downstream accepts out_data.
REQ-016 out_src  output  SEL_W  index of channel that supplied out_data.

Function
REQ-017 SHALL hold one output register; slot is "free" when out_valid=0 or (out_valid & out_ready).
REQ-018 Fixed mode: grant = sel when sel < NUM_IN and in_valid[sel]=1; else no grant.
REQ-019 Round-robin mode: grant = first i with in_valid[i]=1, scanning ptr, ptr+1, ... wrapping NUM_IN-1 -> 0; no grant when in_valid=0.
REQ-020 in_ready[grant] SHALL be 1 only when grant exists, slot free and flush=0; all other bits 0 (combinational).
REQ-021 Transfer (in_valid & in_ready on grant) SHALL load out_data, out_src=grant, out_valid=1 on the next edge; latency exactly 1 cycle.
REQ-022 After a round-robin transfer, ptr SHALL become (grant+1) mod NUM_IN; ptr unchanged in fixed mode and on cycles without transfer.
REQ-023 Simultaneous drain and transfer in the same cycle SHALL sustain one word per cycle with no bubble.
REQ-024 Drain without transfer SHALL clear out_valid next edge.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_src SHALL be stable.
REQ-026 flush=1 SHALL clear out_valid and set ptr=0 on next edge, overriding transfer and drain; in_ready=0 during flush.
REQ-027 mode or sel changes SHALL affect only the grant of the current cycle, never a word already held.
REQ-028 sel >= NUM_IN (non-power-of-2 NUM_IN) SHALL yield no grant, never X.

Reset
REQ-029 rst_n=0 at a rising edge SHALL set out_valid=0, out_data=0, out_src=0, ptr=0; in_ready=0 while rst_n=0.
REQ-030 Reset mid-transfer SHALL discard the held word; no transfer completes in a reset cycle.

Structure
REQ-031 Shared package mux_pkg SHALL hold mode encodings (MODE_FIXED=0, MODE_RR=1) and a clog2 helper function.
REQ-032 Grant logic SHALL be a sub-module rr_grant (inputs valid, ptr, mode, sel; outputs grant, grant_vld), purely combinational.
REQ-033 Output register and ptr SHALL reside in mux_arb_reg.

Verification (WIDTH=5, NUM_IN=4)
REQ-034 Fixed: mode=0, sel=2, ch2=5'd31 valid, out_ready=1 -> in_ready=4'b0100; next cycle out_data=31, out_src=2, out_valid=1.
REQ-035 RR: all valid, ch0..3=1,2,3,4, out_ready=1 -> out_data 1,2,3,4,1 on consecutive cycles, ptr wrapping 3->0.
REQ-036 Backpressure: out_valid=1 with 15, out_ready=0 for 3 cycles -> out_data stays 15, in_ready=0; on out_ready=1 next word loads same cycle.
REQ-037 Flush: out_valid=1, ptr=2, flush=1 -> next cycle out_valid=0, ptr=0; next RR grant is lowest valid index.
REQ-038 Reset: rst_n=0 mid-stream -> out_valid=0, out_data=0, out_src=0 after the edge; sel=3 with in_valid[3]=0 in fixed mode -> no transfer.

Source files
------------

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared definitions for the registered arbitrating mux.
//                Holds the arbitration mode encoding and the width helpers
//                that size the channel-index fields.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

   // Arbitration mode selected by the 'mode' input.
   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Channel-index width: never narrower than one bit.
   function automatic int sel_width(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mux_arb_reg_rr_grant.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant
//  Description : Purely combinational grant selection. Fixed mode grants the
//                channel named by sel (if valid and in range); round-robin
//                mode grants the first valid channel at or after ptr,
//                wrapping from NUM_IN-1 back to 0.
//  Ports       : valid     - per-channel valid
//                ptr       - round-robin starting index
//                mode      - 0 fixed select, 1 round-robin
//                sel       - fixed-mode channel index
//                grant     - granted channel index
//                grant_vld - a grant exists this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant
   import mux_pkg::*;
#(
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2
) (
   input  logic [NUM_IN-1:0] valid,
   input  logic [SEL_W-1:0]  ptr,
   input  logic              mode,
   input  logic [SEL_W-1:0]  sel,
   output logic [SEL_W-1:0]  grant,
   output logic              grant_vld
);

   localparam logic [SEL_W:0] c_NUM = (SEL_W+1)'(NUM_IN);

   logic [NUM_IN-1:0] w_rot;   // valid rotated so that bit 0 is channel ptr
   logic [SEL_W:0]    w_sum;   // ptr + offset before wrap

   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      w_rot     = NUM_IN'({valid, valid} >> ptr);
      w_sum     = '0;
      if (mode == MODE_FIXED) begin
         // Comparing against every legal index means an out-of-range sel
         // simply matches nothing.
         for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i) && valid[i]) begin
               grant     = SEL_W'(i);
               grant_vld = 1'b1;
            end
         end
      end else begin
         // Scan downward so the smallest offset from ptr is written last.
         for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
               w_sum = {1'b0, ptr} + (SEL_W+1)'(k);
               if (w_sum >= c_NUM) begin
                  w_sum = w_sum - c_NUM;
               end
               grant     = w_sum[SEL_W-1:0];
               grant_vld = 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mux_arb_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arb_reg
//  Description : NUM_IN-channel arbitrating mux with a single registered
//                output slot. Fixed or round-robin arbitration, valid/ready
//                handshakes on both sides, one word per cycle when the
//                output drains and refills together.
//  Ports       : clk, rst_n          - clock, synchronous active-low reset
//                mode, sel           - arbitration mode / fixed channel
//                flush               - drop held word, reset RR pointer
//                in_data/valid/ready - flattened input channels
//                out_data/valid/src  - held word, its presence and source
//                out_ready           - downstream accepts out_data
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_arb_reg
   import mux_pkg::*;
#(
   parameter  int WIDTH  = 32,
   parameter  int NUM_IN = 4,
   localparam int SEL_W  = sel_width(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    flush,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SEL_W-1:0]        out_src
);

   localparam logic [SEL_W-1:0] c_LAST = SEL_W'(NUM_IN - 1);

   logic [SEL_W-1:0] r_ptr;
   logic [WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0] r_out_src;
   logic             r_out_valid;

   logic [SEL_W-1:0] w_grant;
   logic             w_grant_vld;
   logic             w_slot_free;
   logic             w_xfer;
   logic [SEL_W-1:0] w_ptr_next;
   logic [WIDTH-1:0] w_sel_data;

   rr_grant #(
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) u_grant (
      .valid     (in_valid),
      .ptr       (r_ptr),
      .mode      (mode),
      .sel       (sel),
      .grant     (w_grant),
      .grant_vld (w_grant_vld)
   );

   // The slot can accept a word if it is empty or being drained this cycle.
   assign w_slot_free = !r_out_valid || out_ready;
   // Reset and flush both block acceptance so no word is lost on those edges.
   assign w_xfer      = rst_n && !flush && w_slot_free && w_grant_vld;
   assign in_ready    = w_xfer ? (NUM_IN'(1) << w_grant) : '0;
   assign w_ptr_next  = (w_grant == c_LAST) ? '0 : (w_grant + SEL_W'(1));

   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (w_grant == SEL_W'(i)) begin
            w_sel_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_src   <= '0;
         r_ptr       <= '0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
         r_ptr       <= '0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_sel_data;
         r_out_src   <= w_grant;
         if (mode == MODE_RR) begin
            r_ptr <= w_ptr_next;
         end
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_src   = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_arb_reg
//  Description : Self-checking bench for mux_arb_reg (WIDTH=5, NUM_IN=4):
//                directed vector table, a sustained-throughput sequence and
//                randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_arb_reg;

   localparam int W = 5;
   localparam int N = 4;

   typedef struct {
      logic        rst_n;
      logic        mode;
      logic [1:0]  sel;
      logic        flush;
      logic [3:0]  iv;
      logic [19:0] data;
      logic        ordy;
      logic [3:0]  e_rdy;
      logic        e_ov;
      logic [4:0]  e_od;
      logic [1:0]  e_os;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n, mode, flush, out_ready, out_valid;
   logic [1:0]  sel, out_src;
   logic [19:0] in_data;
   logic [3:0]  in_valid, in_ready;
   logic [4:0]  out_data;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model state
   int m_valid, m_data, m_src, m_ptr;

   always #5 clk = ~clk;

   mux_arb_reg #(.WIDTH(W), .NUM_IN(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .flush     (flush),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_src   (out_src)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [19:0] pack4(input int a, input int b, input int c, input int d);
      logic [4:0] a5, b5, c5, d5;
      a5 = 5'(a); b5 = 5'(b); c5 = 5'(c); d5 = 5'(d);
      return {d5, c5, b5, a5};
   endfunction

   function automatic vec_t mk(input logic r, input logic md, input logic [1:0] s,
                               input logic f, input logic [3:0] iv, input logic [19:0] d,
                               input logic ordy, input logic [3:0] erdy, input logic eov,
                               input int eod, input int eos);
      vec_t v;
      v.rst_n = r; v.mode = md; v.sel = s; v.flush = f; v.iv = iv; v.data = d;
      v.ordy = ordy; v.e_rdy = erdy; v.e_ov = eov; v.e_od = 5'(eod); v.e_os = 2'(eos);
      return v;
   endfunction

   // Spec-level arbitration rule; -1 means no grant.
   function automatic int model_grant(input logic md, input int s, input logic [3:0] iv, input int p);
      int idx;
      if (!md) return (s < N && iv[s]) ? s : -1;
      for (int k = 0; k < N; k++) begin
         idx = (p + k) % N;
         if (iv[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic drive(input vec_t v);
      rst_n = v.rst_n; mode = v.mode; sel = v.sel; flush = v.flush;
      in_valid = v.iv; in_data = v.data; out_ready = v.ordy;
   endtask

   initial begin
      vec_t vecs[$];
      logic [19:0] d_rr, d_b;
      rst_n = 1'b0; mode = 1'b0; sel = '0; flush = 1'b0;
      in_data = '0; in_valid = '0; out_ready = 1'b0;

      d_rr = pack4(1, 2, 3, 4);
      d_b  = pack4(7, 8, 9, 10);
      //                 rst md sel fl  iv       data               ordy rdy      ov od  os
      vecs.push_back(mk(0, 1, 0, 0, 4'b1111, d_rr,               1, 4'b0000, 0, 0,  0)); // reset
      vecs.push_back(mk(1, 0, 2, 0, 4'b0100, pack4(0, 0, 31, 0), 1, 4'b0100, 1, 31, 2)); // fixed sel=2
      vecs.push_back(mk(1, 0, 2, 0, 4'b0000, 20'd0,              1, 4'b0000, 0, 0,  0)); // drain only
      vecs.push_back(mk(1, 0, 3, 0, 4'b0111, d_rr,               1, 4'b0000, 0, 0,  0)); // sel=3 not valid
      vecs.push_back(mk(1, 1, 0, 0, 4'b1111, d_rr,               1, 4'b0001, 1, 1,  0)); // RR sweep
      vecs.push_back(mk(1, 1, 0, 0, 4'b1111, d_rr,               1, 4'b0010, 1, 2,  1));
      vecs.push_back(mk(1, 1, 0, 0, 4'b1111, d_rr,               1, 4'b0100, 1, 3,  2));
      vecs.push_back(mk(1, 1, 0, 0, 4'b1111, d_rr,               1, 4'b1000, 1, 4,  3));
      vecs.push_back(mk(1, 1, 0, 0, 4'b1111, d_rr,               1, 4'b0001, 1, 1,  0)); // wrap 3->0
      vecs.push_back(mk(1, 1, 0, 0, 4'b0010, pack4(0, 15, 0, 0), 1, 4'b0010, 1, 15, 1)); // load 15
      vecs.push_back(mk(1, 1, 0, 0, 4'b1111, d_b,                0, 4'b0000, 1, 15, 1)); // backpressure x3
      vecs.push_back(mk(1, 1, 0, 0, 4'b1111, d_b,                0, 4'b0000, 1, 15, 1));
      vecs.push_back(mk(1, 1, 0, 0, 4'b1111, d_b,                0, 4'b0000, 1, 15, 1));
      vecs.push_back(mk(1, 1, 0, 0, 4'b1111, d_b,                1, 4'b0100, 1, 9,  2)); // release
      vecs.push_back(mk(1, 1, 0, 0, 4'b0010, d_b,                1, 4'b0010, 1, 8,  1)); // ptr -> 2
      vecs.push_back(mk(1, 1, 0, 1, 4'b1111, d_b,                0, 4'b0000, 0, 0,  0)); // flush
      vecs.push_back(mk(1, 1, 0, 0, 4'b1010, d_b,                1, 4'b0010, 1, 8,  1)); // ptr was cleared
      vecs.push_back(mk(0, 1, 0, 0, 4'b1111, d_b,                1, 4'b0000, 0, 0,  0)); // reset mid-stream
      vecs.push_back(mk(1, 1, 0, 0, 4'b1111, d_b,                0, 4'b0001, 1, 7,  0));
      vecs.push_back(mk(1, 1, 0, 0, 4'b1111, d_b,                0, 4'b0000, 1, 7,  0));
      vecs.push_back(mk(0, 1, 0, 0, 4'b1111, d_b,                0, 4'b0000, 0, 0,  0)); // reset drops word
      vecs.push_back(mk(1, 0, 3, 0, 4'b1000, d_b,                0, 4'b1000, 1, 10, 3));
      vecs.push_back(mk(1, 1, 0, 0, 4'b1111, d_rr,               0, 4'b0000, 1, 10, 3)); // mode change while held

      @(negedge clk);
      foreach (vecs[i]) begin
         drive(vecs[i]);
         #1;
         chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
         if (vecs[i].e_ov || !vecs[i].rst_n) begin
            chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].e_od));
            chk($sformatf("vec%0d out_src", i), 32'(out_src), 32'(vecs[i].e_os));
         end
         @(negedge clk);
      end

      // Sustained round-robin with downstream always ready: one word every
      // cycle, no bubble. Pointer is 0 and a word is held from the table.
      rst_n = 1'b1; mode = 1'b1; flush = 1'b0; in_valid = 4'b1111;
      in_data = d_rr; out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk($sformatf("stream%0d in_ready", k), 32'(in_ready), 32'(1 << (k % N)));
         @(posedge clk);
         #1;
         chk($sformatf("stream%0d out_valid", k), 32'(out_valid), 32'd1);
         chk($sformatf("stream%0d out_data", k), 32'(out_data), 32'((k % N) + 1));
         @(negedge clk);
      end

      // Randomized traffic against the model; first cycle resets both.
      m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
      for (int c = 0; c < 2000; c++) begin
         int g;
         logic xfer;
         logic [3:0] e_rdy;
         rst_n     = (c == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         mode      = 1'($urandom);
         sel       = 2'($urandom);
         in_valid  = 4'($urandom);
         in_data   = 20'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         g    = model_grant(mode, int'(sel), in_valid, m_ptr);
         xfer = rst_n && !flush && (m_valid == 0 || out_ready) && (g >= 0);
         e_rdy = xfer ? 4'(1 << g) : 4'b0000;
         #1;
         chk($sformatf("rand%0d in_ready", c), 32'(in_ready), 32'(e_rdy));
         @(posedge clk);
         if (!rst_n) begin
            m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
         end else if (flush) begin
            m_valid = 0; m_ptr = 0;
         end else if (xfer) begin
            m_valid = 1;
            m_data  = int'((in_data >> (g * W)) & 20'h1f);
            m_src   = g;
            if (mode) m_ptr = (g + 1) % N;
         end else if (out_ready) begin
            m_valid = 0;
         end
         #1;
         chk($sformatf("rand%0d out_valid", c), 32'(out_valid), 32'(m_valid));
         if (m_valid != 0) begin
            chk($sformatf("rand%0d out_data", c), 32'(out_data), 32'(m_data));
            chk($sformatf("rand%0d out_src", c), 32'(out_src), 32'(m_src));
         end
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
